// File: rtl/t03_mem_pkg.sv
// Shared types, arbitration-mode constants and the load-extend helper
// for the memory request arbiter.
package t03_mem_pkg;

    typedef enum logic [1:0] {BYTE = 2'b00, HALF = 2'b01, WORD = 2'b10, RSVD = 2'b11} size_t;
    typedef enum logic [1:0] {IDLE = 2'b00, BUS = 2'b01, DONE = 2'b10} state_t;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    // Widest bus the helper supports; callers cast in and out of this width.
    localparam int MAX_DATA_W = 256;
    localparam int MAX_OFF_W  = 5;

    function automatic logic [MAX_DATA_W-1:0] load_extend(
        input logic [MAX_DATA_W-1:0] lane_data,
        input logic [MAX_OFF_W-1:0]  offset,
        input size_t                 size,
        input logic                  is_unsigned
    );
        logic [MAX_DATA_W-1:0] shifted;
        logic [MAX_DATA_W-1:0] result;
        shifted = lane_data >> {offset, 3'b000};
        case (size)
            BYTE:    result = {{(MAX_DATA_W-8){shifted[7] & ~is_unsigned}}, shifted[7:0]};
            HALF:    result = {{(MAX_DATA_W-16){shifted[15] & ~is_unsigned}}, shifted[15:0]};
            default: result = {{(MAX_DATA_W-32){shifted[31] & ~is_unsigned}}, shifted[31:0]};
        endcase
        return result;
    endfunction

endpackage

// File: rtl/t03_mem_req_arbiter_arb.sv
// Grant selection across N_CH requestors: fixed priority or round-robin
// with a pointer holding the most recent grant.
module t03_req_arbiter
    import t03_mem_pkg::*;
#(
    parameter int N_CH     = 2,
    parameter int ARB_MODE = ARB_FIXED,
    localparam int GW      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] req,
    input  logic            advance,
    output logic [GW-1:0]   grant,
    output logic            grant_valid
);

    logic [GW-1:0] r_ptr;

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        grant       = '0;
        grant_valid = 1'b0;
        if (ARB_MODE == ARB_RR) begin
            for (int k = 1; k <= N_CH; k++) begin
                if (!grant_valid && req[(int'(r_ptr) + k) % N_CH]) begin
                    grant       = GW'((int'(r_ptr) + k) % N_CH);
                    grant_valid = 1'b1;
                end
            end
        end else begin
            for (int k = 0; k < N_CH; k++) begin
                if (!grant_valid && req[k]) begin
                    grant       = GW'(k);
                    grant_valid = 1'b1;
                end
            end
        end
    end

    // Reset to the last channel so the first search starts at ch0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr <= GW'(N_CH - 1);
        end else if (advance && grant_valid) begin
            r_ptr <= grant;
        end
    end

endmodule

// File: rtl/t03_mem_req_arbiter.sv
// Multi-channel CPU memory request unit: arbitrates requestors onto one
// ack-handshaked bus with sub-word lanes, load extension and timeout.
module t03_mem_req_arbiter
    import t03_mem_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int N_CH     = 2,
    parameter int ARB_MODE = ARB_FIXED,
    parameter int TIMEOUT  = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_CH-1:0]          req_valid,
    input  logic [N_CH-1:0]          req_write,
    input  logic [N_CH*ADDR_W-1:0]   req_addr,
    input  logic [N_CH*DATA_W-1:0]   req_wdata,
    input  logic [N_CH*2-1:0]        req_size,
    input  logic [N_CH-1:0]          req_unsigned,
    output logic [N_CH-1:0]          ch_busy,
    output logic [N_CH-1:0]          ch_done,
    output logic [N_CH-1:0]          ch_err,
    output logic [DATA_W-1:0]        ch_rdata,
    output logic                     bus_read,
    output logic                     bus_write,
    output logic [ADDR_W-1:0]        bus_addr,
    output logic [DATA_W-1:0]        bus_wdata,
    output logic [DATA_W/8-1:0]      bus_sel,
    input  logic                     bus_ack,
    input  logic [DATA_W-1:0]        bus_rdata
);

    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int GW    = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int TW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    state_t              r_state, w_state_nxt;
    logic [GW-1:0]       r_grant, w_grant;
    logic                w_grant_valid;
    logic [ADDR_W-1:0]   r_addr, w_sel_addr;
    size_t               r_size, w_sel_size;
    logic [DATA_W-1:0]   r_wdata, r_rdata;
    logic                r_unsigned, r_write, r_err;
    logic [TW-1:0]       r_timer;
    logic                w_misalign, w_timeout, w_in_bus;
    logic [NB-1:0]       w_mask;

    t03_req_arbiter #(.N_CH(N_CH), .ARB_MODE(ARB_MODE)) u_arb (
        .clk         (clk),
        .rst         (rst),
        .req         (req_valid),
        .advance     (r_state == IDLE),
        .grant       (w_grant),
        .grant_valid (w_grant_valid)
    );

    assign w_sel_addr = req_addr[int'(w_grant)*ADDR_W +: ADDR_W];
    assign w_sel_size = size_t'(req_size[int'(w_grant)*2 +: 2]);
    assign w_misalign = (w_sel_size == RSVD)
                     || (w_sel_size == HALF && w_sel_addr[0])
                     || (w_sel_size == WORD && w_sel_addr[1:0] != 2'b00);
    // An ack in the timeout cycle takes precedence over the error.
    assign w_timeout  = (TIMEOUT != 0) && (r_timer == TW'(TIMEOUT)) && !bus_ack;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_grant_valid) w_state_nxt = w_misalign ? DONE : BUS;
            BUS:     if (bus_ack || w_timeout) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_grant    <= '0;
            r_addr     <= '0;
            r_size     <= BYTE;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_unsigned <= 1'b0;
            r_write    <= 1'b0;
            r_err      <= 1'b0;
            r_timer    <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            r_state <= w_state_nxt;
            case (r_state)
                IDLE: begin
                    if (w_grant_valid) begin
                        r_grant    <= w_grant;
                        r_addr     <= w_sel_addr;
                        r_size     <= w_sel_size;
                        r_wdata    <= req_wdata[int'(w_grant)*DATA_W +: DATA_W];
                        r_unsigned <= req_unsigned[w_grant];
                        r_write    <= req_write[w_grant];
                        r_err      <= w_misalign;
                        r_timer    <= '0;
                        r_rdata    <= '0;
                    end
                end
                BUS: begin
                    if (bus_ack) begin
                        r_rdata <= DATA_W'(load_extend(MAX_DATA_W'(bus_rdata),
                                                       MAX_OFF_W'(r_addr[OFF_W-1:0]),
                                                       r_size, r_unsigned));
                    end else if (w_timeout) begin
                        r_err <= 1'b1;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign w_in_bus  = (r_state == BUS);
    assign bus_read  = w_in_bus & ~r_write;
    assign bus_write = w_in_bus &  r_write;

    always_comb begin
        case (r_size)
            BYTE:    w_mask = NB'(1);
            HALF:    w_mask = NB'(3);
            default: w_mask = NB'(15);
        endcase
    end

    always_comb begin
        bus_addr  = '0;
        bus_sel   = '0;
        bus_wdata = '0;
        if (w_in_bus) begin
            bus_addr = r_addr & ~ADDR_W'(NB - 1);
            bus_sel  = w_mask << r_addr[OFF_W-1:0];
            case (r_size)
                BYTE:    bus_wdata = {NB{r_wdata[7:0]}};
                HALF:    bus_wdata = {(NB/2){r_wdata[15:0]}};
                default: bus_wdata = {(DATA_W/32){r_wdata[31:0]}};
            endcase
        end
    end

    assign ch_done  = (r_state == DONE) ? (N_CH'(1) << r_grant) : '0;
    assign ch_err   = ch_done & {N_CH{r_err}};
    assign ch_busy  = req_valid & ~ch_done;
    assign ch_rdata = r_rdata;

endmodule

// File: tb/tb_t03_mem_req_arbiter.sv
// Randomized scoreboard bench: a spec-level model predicts bus beats and
// completions; bus-responder and completion monitors check them independently.
module tb_t03_mem_req_arbiter;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  req_valid, req_write, req_unsigned;
    logic [63:0] req_addr, req_wdata;
    logic [3:0]  req_size;
    logic [1:0]  ch_busy, ch_done, ch_err;
    logic [31:0] ch_rdata, bus_addr, bus_wdata, bus_rdata;
    logic        bus_read, bus_write, bus_ack;
    logic [3:0]  bus_sel;

    logic [1:0]  fx_valid, fx_busy, fx_done, fx_err;
    logic [31:0] fx_rdata, fx_addr, fx_wdata, fx_bus_rdata;
    logic        fx_read, fx_write, fx_ack;
    logic [3:0]  fx_sel;

    always #5 clk = ~clk;

    t03_mem_req_arbiter #(.ADDR_W(32), .DATA_W(32), .N_CH(2), .ARB_MODE(1), .TIMEOUT(TMO)) u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .req_unsigned(req_unsigned), .ch_busy(ch_busy), .ch_done(ch_done),
        .ch_err(ch_err), .ch_rdata(ch_rdata), .bus_read(bus_read),
        .bus_write(bus_write), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_sel(bus_sel), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    t03_mem_req_arbiter #(.ADDR_W(32), .DATA_W(32), .N_CH(2), .ARB_MODE(0), .TIMEOUT(TMO)) u_fx (
        .clk(clk), .rst(rst), .req_valid(fx_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .req_unsigned(req_unsigned), .ch_busy(fx_busy), .ch_done(fx_done),
        .ch_err(fx_err), .ch_rdata(fx_rdata), .bus_read(fx_read),
        .bus_write(fx_write), .bus_addr(fx_addr), .bus_wdata(fx_wdata),
        .bus_sel(fx_sel), .bus_ack(fx_ack), .bus_rdata(fx_bus_rdata)
    );

    typedef struct {
        int          ch;
        bit          err;
        bit          write;
        logic [31:0] rdata;
    } exp_t;

    typedef struct {
        bit          write;
        logic [31:0] addr;
        logic [3:0]  sel;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          delay;
        bit          noack;
        bit          abort;
    } bus_t;

    exp_t exp_q[$];
    bus_t bus_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   last_ch = 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Spec-level model: lanes, byte selects and extension from plain arithmetic.
    function automatic void model(input logic [31:0] addr, input int size, input logic [31:0] wdata,
                                  input bit uns, input logic [31:0] rdata, output bit err,
                                  output logic [31:0] b_addr, output logic [3:0] sel,
                                  output logic [31:0] b_wdata, output logic [31:0] ld);
        int     nb;
        int     off;
        longint v;
        nb  = (size == 3) ? 4 : (1 << size);
        off = int'(addr % 4);
        err = (size == 3) || (addr % nb != 0);
        b_addr = addr - off;
        sel = 4'(((1 << nb) - 1) << off);
        b_wdata = '0;
        for (int j = 0; j < 4; j++) b_wdata[8*j +: 8] = wdata[8*(j % nb) +: 8];
        v = longint'(rdata >> (8 * off)) & ((longint'(1) << (8 * nb)) - 1);
        if (!uns && v >= (longint'(1) << (8 * nb - 1))) v = v - (longint'(1) << (8 * nb));
        ld = v[31:0];
    endfunction

    task automatic issue(input int ch, input bit write, input logic [31:0] addr, input int size,
                         input logic [31:0] wdata, input bit uns, input logic [31:0] rdata,
                         input int delay, input bit noack, input string tag);
        bit          err, got;
        logic [31:0] b_addr, b_wdata, ld;
        logic [3:0]  sel;
        int          lat, exp_lat;
        model(addr, size, wdata, uns, rdata, err, b_addr, sel, b_wdata, ld);
        exp_q.push_back('{ch, err || noack, write, ld});
        if (!err) bus_q.push_back('{write, b_addr, sel, b_wdata, rdata, delay, noack, 1'b0});
        req_addr[ch*32 +: 32]  = addr;
        req_wdata[ch*32 +: 32] = wdata;
        req_size[ch*2 +: 2]    = 2'(size);
        req_write[ch]          = write;
        req_unsigned[ch]       = uns;
        req_valid[ch]          = 1'b1;
        last_ch                = ch;
        #1 check({tag, "_busy_on"}, ch_busy[ch], 1);
        lat = 0;
        got = 1'b0;
        while (lat < 40 && !got) begin
            @(negedge clk);
            lat++;
            got = ch_done[ch];
        end
        check({tag, "_done_seen"}, got, 1);
        exp_lat = err ? 1 : (noack ? 2 + TMO : 2 + delay);
        if (got) begin
            check({tag, "_latency"}, lat, exp_lat);
            #1 check({tag, "_busy_off"}, ch_busy[ch], 0);
        end
        req_valid[ch] = 1'b0;
        @(negedge clk);
    endtask

    // Completion monitor.
    initial begin
        exp_t       e;
        logic [1:0] oh;
        forever begin
            @(negedge clk);
            if (ch_done != 2'b00 || ch_err != 2'b00) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", {ch_done, ch_err}, 0);
                end else begin
                    e  = exp_q.pop_front();
                    oh = 2'(1 << e.ch);
                    check("done_ch", ch_done, oh);
                    check("done_err", ch_err, e.err ? oh : 2'b00);
                    if (!e.err && !e.write) check("load_data", ch_rdata, e.rdata);
                end
            end
        end
    end

    // Bus responder and bus-side monitor.
    initial begin
        bus_t b;
        int   cnt;
        bus_ack   = 1'b0;
        bus_rdata = '0;
        forever begin
            @(negedge clk);
            bus_ack = 1'b0;
            if (bus_read || bus_write) begin
                if (bus_q.size() == 0) begin
                    check("unexpected_strobe", {bus_read, bus_write}, 0);
                end else begin
                    b = bus_q.pop_front();
                    check("bus_write", bus_write, b.write);
                    check("bus_read", bus_read, !b.write);
                    check("bus_addr", bus_addr, b.addr);
                    check("bus_sel", bus_sel, b.sel);
                    if (b.write) check("bus_wdata", bus_wdata, b.wdata);
                    if (b.noack) begin
                        cnt = 1;
                        for (int k = 0; k < 20; k++) begin
                            @(negedge clk);
                            if (bus_read || bus_write) cnt++;
                            else break;
                        end
                        if (!b.abort) check("timeout_strobe_cycles", cnt, TMO + 1);
                    end else begin
                        for (int k = 0; k < b.delay; k++) begin
                            @(negedge clk);
                            check("strobe_hold", {bus_read, bus_write}, b.write ? 2'b01 : 2'b10);
                            check("addr_hold", bus_addr, b.addr);
                        end
                        bus_rdata = b.rdata;
                        bus_ack   = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n, k, g, r, sz;
        logic [31:0] rd;
        req_valid = '0; req_write = '0; req_unsigned = '0;
        req_addr = '0; req_wdata = '0; req_size = '0;
        fx_valid = '0; fx_ack = 1'b1; fx_bus_rdata = 32'h5A5A_5A5A;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_done", ch_done, 0);
        check("rst_err", ch_err, 0);
        check("rst_strobes", {bus_read, bus_write}, 0);
        check("rst_bus_addr", bus_addr, 0);
        check("rst_bus_sel", bus_sel, 0);
        check("rst_bus_wdata", bus_wdata, 0);
        check("rst_rdata", ch_rdata, 0);
        rst = 1'b1;

        issue(0, 0, 32'h100, 2, 32'h0, 0, 32'h1234_5678, 0, 0, "word_rd");
        issue(1, 0, 32'h203, 0, 32'h0, 0, 32'h80FF_FF11, 0, 0, "byte_s");
        issue(1, 0, 32'h203, 0, 32'h0, 1, 32'h80FF_FF11, 1, 0, "byte_u");
        issue(1, 1, 32'h12,  1, 32'hABCD, 0, 32'h0, 2, 0, "half_st");
        issue(1, 0, 32'h6,   2, 32'h0, 0, 32'h0, 0, 0, "misalign");
        issue(0, 0, 32'h41,  1, 32'h0, 0, 32'h0, 0, 0, "half_odd");
        issue(0, 1, 32'h40,  3, 32'h0, 0, 32'h0, 0, 0, "rsvd");
        issue(0, 0, 32'h22,  1, 32'h0, 0, 32'h9876_0000, 0, 0, "half_hi");

        for (int i = 0; i < 40; i++) begin
            r  = $urandom_range(0, 9);
            sz = (r < 3) ? 0 : (r < 6) ? 1 : (r < 9) ? 2 : 3;
            issue($urandom_range(0, 1), 1'($urandom_range(0, 1)), $urandom & 32'hFFFF, sz,
                  $urandom, 1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 3),
                  $urandom_range(0, 11) == 0, "rand");
        end

        // Both channels held: round-robin must alternate from the last grant.
        req_addr = {32'h80, 32'h40};
        req_size = 4'b1010;
        req_write = 2'b00;
        req_unsigned = 2'b11;
        for (int i = 0; i < 6; i++) begin
            g  = (last_ch + 1) % 2;
            rd = $urandom;
            exp_q.push_back('{g, 1'b0, 1'b0, rd});
            bus_q.push_back('{1'b0, (g == 0) ? 32'h40 : 32'h80, 4'hF, 32'h0, rd, 0, 1'b0, 1'b0});
            last_ch = g;
        end
        req_valid = 2'b11;
        n = 0;
        k = 0;
        while (n < 6 && k < 80) begin
            @(negedge clk);
            k++;
            if (ch_done != 2'b00) n++;
        end
        req_valid = 2'b00;
        check("rr_done_count", n, 6);
        @(negedge clk);

        // Fixed-priority instance: ch0 wins every time with ch1 also waiting.
        fx_valid = 2'b11;
        n = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (fx_done != 2'b00) begin
                n++;
                check("fx_grant", fx_done, 2'b01);
                check("fx_ch1_busy", fx_busy[1], 1);
            end
        end
        fx_valid = 2'b00;
        check("fx_pulses", n, 10);
        repeat (3) @(negedge clk);

        issue(0, 0, 32'h300, 2, 32'h0, 0, 32'h0, 0, 1, "timeout");

        // Reset during BUS: strobes drop at once, no completion follows.
        bus_q.push_back('{1'b0, 32'h400, 4'hF, 32'h0, 32'h0, 0, 1'b1, 1'b1});
        req_addr[31:0] = 32'h400;
        req_size[1:0]  = 2'b10;
        req_write[0]   = 1'b0;
        req_valid[0]   = 1'b1;
        repeat (2) @(negedge clk);
        check("pre_rst_strobe", bus_read, 1);
        #2 rst = 1'b0;
        #1 check("rst_mid_strobes", {bus_read, bus_write}, 0);
        check("rst_mid_done", ch_done, 0);
        req_valid = 2'b00;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (6) @(negedge clk);
        check("exp_q_drained", exp_q.size(), 0);
        check("bus_q_drained", bus_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/t03_mem_req_arbiter.md
Name: t03_mem_req_arbiter

Overview:
Parametrised successor to the single-port request unit. Arbitrates N_CH CPU-side requestors (ch0 = instruction fetch, ch1 = load/store, further channels for later DMA/peripheral masters) onto one ack-handshaked memory bus. Adds sub-word access with byte selects, read-data alignment and sign/zero extension, misalignment detection and a bus timeout. Sits between the CPU core and the memory/wishbone bridge, replacing the freeze-PC/freeze-instruction logic with per-channel busy/done/err signals.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, bus data width; power of two, at least 32
N_CH, 2, number of requestor channels (1..8)
ARB_MODE, 0, 0 = fixed priority (lowest index wins), 1 = round-robin
TIMEOUT, 255, cycles to wait for bus_ack before error; 0 disables timeout

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset (0 = reset asserted)
req_valid  in  N_CH  channel i requests an access; held until ch_done[i]
req_write  in  N_CH  1 = store, 0 = load
req_addr  in  N_CH*ADDR_W  byte address, channel i at slice i
req_wdata  in  N_CH*DATA_W  store data, right-aligned
req_size  in  N_CH*2  00 byte, 01 half, 10 word, 11 reserved (flagged as err)
req_unsigned  in  N_CH  1 = zero-extend load, 0 = sign-extend load
ch_busy  out  N_CH  freeze for channel i; replaces freezePc/freezeInstr
ch_done  out  N_CH  one-cycle completion pulse
ch_err  out  N_CH  one-cycle pulse together with ch_done on misalign, reserved size or timeout
ch_rdata  out  DATA_W  aligned and extended load data; valid while ch_done is high
bus_read  out  1  bus read strobe
bus_write  out  1  bus write strobe
bus_addr  out  ADDR_W  word-aligned bus address
bus_wdata  out  DATA_W  lane-replicated store data
bus_sel  out  DATA_W/8  byte-lane enables
bus_ack  in  1  bus completion
bus_rdata  in  DATA_W  bus read data

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; all outputs 0; RR pointer = N_CH-1, so ch0 has first priority. Reset mid-transaction drops the strobes at once. The in-flight access is lost and no done pulse is sent.
- FSM IDLE -> BUS -> DONE -> IDLE. IDLE -> DONE directly on an error found at grant time.
- IDLE: if any req_valid, the arbiter picks a grant. The grant, address, size, write data and unsigned flag are latched. Misaligned access (half with addr[0]=1, word with addr[1:0]!=0) or size 11 -> err, DONE, with no bus cycle.
- BUS: bus_read or bus_write held high, with addr, wdata and sel stable, until bus_ack. Timer counts from 0. If the timer reaches TIMEOUT with no ack -> err, DONE, strobes dropped. An ack arriving in the same cycle as the timeout wins.
- On ack: bus_rdata is captured. The selected lane is shifted down by the addr low bits, then extended by size and req_unsigned.
- DONE: ch_done[grant]=1 for one cycle (plus ch_err if flagged), then IDLE. The requestor may present a new request in the same DONE cycle; it is sampled in the next IDLE cycle.
- Latency: minimum 3 cycles from req_valid to ch_done with an ack in the first BUS cycle. Error-at-grant takes 2 cycles.
- ch_busy[i] = req_valid[i] and not (state==DONE and grant==i). This is combinational.
- Store lanes: byte data is replicated across every lane, half data across every half. bus_sel = size mask (1, 3, 0xF) shifted left by addr[log2(DATA_W/8)-1:0]. bus_addr has its low lane bits cleared.
- Round-robin search starts at pointer+1 and wraps modulo N_CH. The pointer updates to the grant at every grant, including error grants. Fixed mode ignores the pointer.
- A requestor that drops req_valid while granted does not abort the access; the done pulse still fires.
- An unexpected bus_ack in IDLE or DONE is ignored.

Decomposition:
- t03_mem_pkg holds:
  - size_t enum (BYTE, HALF, WORD, RSVD)
  - state_t enum (IDLE, BUS, DONE)
  - ARB_FIXED and ARB_RR constants
  - a load-extend function (lane data, offset, size, unsigned) -> DATA_W
- One sub-module, t03_req_arbiter (parameters N_CH and ARB_MODE; ports req, advance, grant, grant_valid), holds the RR pointer.

Test Plan:
- Reset with ch0 word read at 0x100 valid; ack 1 cycle after bus_read -> bus_addr 0x100, bus_sel 0xF, ch_done[0] on cycle 3, ch_rdata = bus_rdata.
- ch1 signed byte load at 0x203, bus_rdata 0x80FF_FF11 -> bus_sel 0x8, ch_rdata 0xFFFF_FF80. Same access unsigned -> 0x0000_0080.
- ch1 half store 0xABCD at 0x12 -> bus_addr 0x10, bus_wdata 0xABCD_ABCD, bus_sel 0xC, bus_write high until ack.
- ch1 word load at 0x6 -> no bus strobe, ch_done[1] and ch_err[1] on cycle 2.
- ARB_MODE=1 with both channels held valid continuously -> grants alternate 0,1,0,1. ARB_MODE=0 -> ch0 repeatedly.
- TIMEOUT=4, no ack -> strobe for 5 cycles then ch_err. Second run with rst pulled to 0 mid-BUS -> strobes 0 immediately, no ch_done.
